// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared encodings and defaults for the SPI arbiter slice.
// Revision : 1.0
// ============================================================================
package spi_pkg;

    localparam int GAP_CYCLES_DEFAULT = 4;
    localparam int CNT_W              = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_XFER    = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; the requester not served last wins ties.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import spi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last_served);
        grant[1] = req[1] & (~req[0] | ~last_served);
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Shares one SPI master between two requesters with round-robin
//            arbitration and an enforced idle gap after chip select rises.
// Revision : 1.0
// ============================================================================
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [7:0]  len_i,
    input  logic [15:0] tx_data_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic [1:0]  rx_valid_o,
    output logic [1:0]  done_o,
    output logic        busy_o,
    output logic        m_en_o,
    output logic [7:0]  m_mosi_data_o,
    input  logic [7:0]  m_miso_data_i,
    input  logic        m_data_ready_i,
    input  logic        m_cs_i
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]       state_q,    state_d;
    logic             owner_q,    owner_d;
    logic             last_q,     last_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [1:0]       gnt_q,      gnt_d;
    logic [1:0]       tx_ready_q, tx_ready_d;
    logic [1:0]       rx_valid_q, rx_valid_d;
    logic [1:0]       done_q,     done_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             m_en_q,     m_en_d;
    logic [7:0]       mosi_q,     mosi_d;

    logic [1:0] arb_gnt;
    logic       win_idx;
    logic [3:0] win_len;
    logic [7:0] win_tx;
    logic [7:0] owner_tx;

    rr_arb2 u_rr_arb2 (
        .req         (req_i),
        .last_served (last_q),
        .grant       (arb_gnt)
    );

    assign win_idx  = arb_gnt[1];
    assign win_len  = win_idx ? len_i[7:4] : len_i[3:0];
    assign win_tx   = win_idx ? tx_data_i[15:8] : tx_data_i[7:0];
    assign owner_tx = owner_q ? tx_data_i[15:8] : tx_data_i[7:0];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        count_d    = count_q;
        gap_cnt_d  = gap_cnt_q;
        gnt_d      = gnt_q;
        tx_ready_d = 2'b00;
        rx_valid_d = 2'b00;
        done_d     = 2'b00;
        rx_data_d  = rx_data_q;
        m_en_d     = m_en_q;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    owner_d    = win_idx;
                    last_d     = win_idx;
                    gnt_d      = arb_gnt;
                    count_d    = {1'b0, win_len} + CNT_W'(1);
                    mosi_d     = win_tx;
                    tx_ready_d = arb_gnt;
                    m_en_d     = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (m_data_ready_i) begin
                    rx_data_d  = m_miso_data_i;
                    rx_valid_d = idx_to_onehot(owner_q);
                    if (count_q > CNT_W'(1)) begin
                        count_d    = count_q - CNT_W'(1);
                        mosi_d     = owner_tx;
                        tx_ready_d = idx_to_onehot(owner_q);
                    end else begin
                        // Final byte: release the master but hold the grant until the gap ends.
                        m_en_d  = 1'b0;
                        done_d  = idx_to_onehot(owner_q);
                        state_d = ST_WAIT_CS;
                    end
                end
            end
            ST_WAIT_CS: begin
                if (m_cs_i) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            count_q    <= '0;
            gap_cnt_q  <= '0;
            gnt_q      <= 2'b00;
            tx_ready_q <= 2'b00;
            rx_valid_q <= 2'b00;
            done_q     <= 2'b00;
            rx_data_q  <= 8'h00;
            m_en_q     <= 1'b0;
            mosi_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            count_q    <= count_d;
            gap_cnt_q  <= gap_cnt_d;
            gnt_q      <= gnt_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            m_en_q     <= m_en_d;
            mosi_q     <= mosi_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_valid_o    = rx_valid_q;
    assign done_o        = done_q;
    assign rx_data_o     = rx_data_q;
    assign m_en_o        = m_en_q;
    assign m_mosi_data_o = mosi_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Scoreboard bench for spi_arbiter with a behavioural SPI master/slave.
// Revision : 1.0
// ============================================================================
module tb_spi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [7:0]  len_i;
    logic [15:0] tx_data_i;
    logic [1:0]  gnt_o;
    logic [1:0]  tx_ready_o;
    logic [7:0]  rx_data_o;
    logic [1:0]  rx_valid_o;
    logic [1:0]  done_o;
    logic        busy_o;
    logic        m_en_o;
    logic [7:0]  m_mosi_data_o;
    logic [7:0]  m_miso_data_i;
    logic        m_data_ready_i;
    logic        m_cs_i;

    logic mdr_model;
    logic stray_ready;
    assign m_data_ready_i = mdr_model | stray_ready;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int cs_rise_cyc = 0;

    logic [7:0] tx_q0[$];
    logic [7:0] tx_q1[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] slave_q[$];
    logic [8:0] exp_rx[$];
    int tx_cnt[2];
    int rx_cnt[2];
    int done_cnt[2];

    spi_arbiter #(.GAP_CYCLES(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .len_i          (len_i),
        .tx_data_i      (tx_data_i),
        .gnt_o          (gnt_o),
        .tx_ready_o     (tx_ready_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .m_en_o         (m_en_o),
        .m_mosi_data_o  (m_mosi_data_o),
        .m_miso_data_i  (m_miso_data_i),
        .m_data_ready_i (m_data_ready_i),
        .m_cs_i         (m_cs_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural SPI master (mode 0) plus slave: 8 cycles per byte, CS held across bytes.
    initial begin
        int phase;
        int bitc;
        int tail;
        bit do_cap;
        logic [7:0] exp_b;
        phase = 0; bitc = 0; tail = 0;
        m_cs_i = 1'b1; mdr_model = 1'b0; m_miso_data_i = 8'hEE;
        forever begin
            @(negedge clk_i);
            mdr_model = 1'b0;
            do_cap = 1'b0;
            case (phase)
                0: if (m_en_o === 1'b1) begin
                    m_cs_i = 1'b0; do_cap = 1'b1; bitc = 0; phase = 1;
                end
                1: if (m_en_o !== 1'b1) begin
                    m_cs_i = 1'b1; m_miso_data_i = 8'hEE; phase = 0;
                end else begin
                    bitc++;
                    if (bitc == 8) begin
                        m_miso_data_i = (slave_q.size() != 0) ? slave_q.pop_front() : 8'hFF;
                        mdr_model = 1'b1;
                        phase = 2;
                    end
                end
                2: if (m_en_o === 1'b1) begin
                    do_cap = 1'b1; bitc = 0; phase = 1;
                end else begin
                    tail = 2; phase = 3;
                end
                default: begin
                    tail--;
                    if (tail == 0) begin
                        m_cs_i = 1'b1; m_miso_data_i = 8'hEE; cs_rise_cyc = cyc; phase = 0;
                    end
                end
            endcase
            if (do_cap) begin
                chk_cnt++;
                if (exp_mosi.size() == 0) begin
                    $display("FAIL mosi_byte: got %02h, required no byte", m_mosi_data_o);
                end else begin
                    exp_b = exp_mosi.pop_front();
                    if (m_mosi_data_o !== exp_b)
                        $display("FAIL mosi_byte: got %02h, required %02h", m_mosi_data_o, exp_b);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    // Monitor: pulse legality, rx scoreboard, and requester-side tx byte feeder.
    initial begin
        logic [8:0] exp_r;
        logic [8:0] got_r;
        forever begin
            @(negedge clk_i);
            if (tx_ready_o !== 2'b00) begin
                chk_cnt++;
                if (!$onehot(tx_ready_o) || ((tx_ready_o & ~gnt_o) != 2'b00))
                    $display("FAIL tx_ready_owner: got tx_ready=%b gnt=%b", tx_ready_o, gnt_o);
                else
                    pass_cnt++;
                if (tx_ready_o[0]) begin tx_cnt[0]++; if (tx_q0.size() != 0) void'(tx_q0.pop_front()); end
                if (tx_ready_o[1]) begin tx_cnt[1]++; if (tx_q1.size() != 0) void'(tx_q1.pop_front()); end
            end
            if (rx_valid_o !== 2'b00) begin
                chk_cnt++;
                got_r = {rx_valid_o[1], rx_data_o};
                if (exp_rx.size() == 0) begin
                    $display("FAIL rx_data: got %03h, required no rx", got_r);
                end else begin
                    exp_r = exp_rx.pop_front();
                    if (!$onehot(rx_valid_o) || ((rx_valid_o & ~gnt_o) != 2'b00) || got_r !== exp_r)
                        $display("FAIL rx_data: got valid=%b data=%02h, required req%0d data=%02h",
                                 rx_valid_o, rx_data_o, exp_r[8], exp_r[7:0]);
                    else
                        pass_cnt++;
                end
                if (rx_valid_o[0]) rx_cnt[0]++;
                if (rx_valid_o[1]) rx_cnt[1]++;
            end
            if (done_o !== 2'b00) begin
                chk_cnt++;
                if (!$onehot(done_o) || ((done_o & ~gnt_o) != 2'b00))
                    $display("FAIL done_owner: got done=%b gnt=%b", done_o, gnt_o);
                else
                    pass_cnt++;
                if (done_o[0]) done_cnt[0]++;
                if (done_o[1]) done_cnt[1]++;
            end
            tx_data_i = {(tx_q1.size() != 0) ? tx_q1[0] : 8'h00,
                         (tx_q0.size() != 0) ? tx_q0[0] : 8'h00};
        end
    end

    task automatic wait_done(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if (done_o[k]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_gnt(input logic [1:0] g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (gnt_o === g) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_cnt++;
        if ({gnt_o, tx_ready_o, rx_valid_o, done_o} !== 8'h00)
            $display("FAIL reset_pulses: got %02h, required 00", {gnt_o, tx_ready_o, rx_valid_o, done_o});
        else pass_cnt++;
        chk_cnt++;
        if ({busy_o, m_en_o} !== 2'b00)
            $display("FAIL reset_busy_en: got %b, required 00", {busy_o, m_en_o});
        else pass_cnt++;
        chk_cnt++;
        if ({m_mosi_data_o, rx_data_o} !== 16'h0000)
            $display("FAIL reset_data: got %04h, required 0000", {m_mosi_data_o, rx_data_o});
        else pass_cnt++;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single;
        bit ok;
        int d0;
        d0 = done_cnt[0];
        tx_q0.push_back(8'hB6); exp_mosi.push_back(8'hB6);
        slave_q.push_back(8'hA1); exp_rx.push_back({1'b0, 8'hA1});
        len_i = 8'h00;
        @(negedge clk_i);
        req_i = 2'b01;
        @(negedge clk_i);
        chk_cnt++;
        if ({gnt_o, tx_ready_o, m_en_o, busy_o} !== 6'b01_01_1_1)
            $display("FAIL single_grant: got gnt=%b txr=%b en=%b busy=%b, required 01 01 1 1",
                     gnt_o, tx_ready_o, m_en_o, busy_o);
        else pass_cnt++;
        wait_done(0, ok);
        chk_cnt++;
        if (!ok) $display("FAIL single_done: got timeout, required done_o[0]");
        else pass_cnt++;
        req_i = 2'b00;
        chk_cnt++;
        if ({m_en_o, rx_valid_o, rx_data_o} !== {1'b0, 2'b01, 8'hA1})
            $display("FAIL single_end: got en=%b rxv=%b rx=%02h, required 0 01 a1", m_en_o, rx_valid_o, rx_data_o);
        else pass_cnt++;
        wait_idle(ok);
        chk_cnt++;
        if (!ok || done_cnt[0] - d0 != 1)
            $display("FAIL single_count: got done=%0d idle=%0d, required 1 1", done_cnt[0] - d0, ok);
        else pass_cnt++;
    endtask

    task automatic test_burst;
        bit ok;
        int d1, t1, r1;
        d1 = done_cnt[1]; t1 = tx_cnt[1]; r1 = rx_cnt[1];
        tx_q1.push_back(8'hA2); tx_q1.push_back(8'h3C); tx_q1.push_back(8'h5D);
        exp_mosi.push_back(8'hA2); exp_mosi.push_back(8'h3C); exp_mosi.push_back(8'h5D);
        slave_q.push_back(8'hC4); slave_q.push_back(8'h11); slave_q.push_back(8'h22);
        exp_rx.push_back({1'b1, 8'hC4}); exp_rx.push_back({1'b1, 8'h11}); exp_rx.push_back({1'b1, 8'h22});
        len_i = 8'h20;
        @(negedge clk_i);
        req_i = 2'b10;
        wait_done(1, ok);
        req_i = 2'b00;
        chk_cnt++;
        if (!ok) $display("FAIL burst_done: got timeout, required done_o[1]");
        else pass_cnt++;
        wait_idle(ok);
        chk_cnt++;
        if (!ok || rx_cnt[1] - r1 != 3 || tx_cnt[1] - t1 != 3 || done_cnt[1] - d1 != 1)
            $display("FAIL burst_counts: got rx=%0d tx=%0d done=%0d, required 3 3 1",
                     rx_cnt[1] - r1, tx_cnt[1] - t1, done_cnt[1] - d1);
        else pass_cnt++;
    endtask

    task automatic test_contention;
        bit ok;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        tx_q0.push_back(8'h11); tx_q1.push_back(8'h22);
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22);
        slave_q.push_back(8'h55); slave_q.push_back(8'h66);
        exp_rx.push_back({1'b0, 8'h55}); exp_rx.push_back({1'b1, 8'h66});
        len_i = 8'h00;
        @(negedge clk_i);
        req_i = 2'b11;
        @(negedge clk_i);
        chk_cnt++;
        if (gnt_o !== 2'b01) $display("FAIL contend_first: got %b, required 01", gnt_o);
        else pass_cnt++;
        wait_done(0, ok);
        req_i = 2'b10;
        wait_gnt(2'b10, ok);
        chk_cnt++;
        if (!ok || cyc - cs_rise_cyc != 6)
            $display("FAIL contend_gap: got %0d cycles (seen=%0d), required 6", cyc - cs_rise_cyc, ok);
        else pass_cnt++;
        wait_done(1, ok);
        req_i = 2'b00;
        wait_idle(ok);
        tx_q0.push_back(8'h33); tx_q1.push_back(8'h44);
        exp_mosi.push_back(8'h33); exp_mosi.push_back(8'h44);
        slave_q.push_back(8'h77); slave_q.push_back(8'h88);
        exp_rx.push_back({1'b0, 8'h77}); exp_rx.push_back({1'b1, 8'h88});
        @(negedge clk_i);
        req_i = 2'b11;
        @(negedge clk_i);
        chk_cnt++;
        if (gnt_o !== 2'b01) $display("FAIL contend_after1: got %b, required 01", gnt_o);
        else pass_cnt++;
        wait_done(0, ok);
        wait_gnt(2'b10, ok);
        chk_cnt++;
        if (!ok) $display("FAIL contend_rotate: got gnt=%b, required 10", gnt_o);
        else pass_cnt++;
        wait_done(1, ok);
        req_i = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_drop;
        bit ok;
        int d0, r0, t0;
        d0 = done_cnt[0]; r0 = rx_cnt[0]; t0 = tx_cnt[0];
        for (int i = 0; i < 4; i++) begin
            tx_q0.push_back(8'hD0 + 8'(i)); exp_mosi.push_back(8'hD0 + 8'(i));
            slave_q.push_back(8'hE0 + 8'(i)); exp_rx.push_back({1'b0, 8'hE0 + 8'(i)});
        end
        len_i = 8'h03;
        @(negedge clk_i);
        req_i = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (rx_valid_o[0]) begin ok = 1'b1; break; end
        end
        req_i = 2'b00;
        wait_done(0, ok);
        chk_cnt++;
        if (!ok) $display("FAIL drop_done: got timeout, required done_o[0]");
        else pass_cnt++;
        wait_idle(ok);
        chk_cnt++;
        if (rx_cnt[0] - r0 != 4 || tx_cnt[0] - t0 != 4 || done_cnt[0] - d0 != 1)
            $display("FAIL drop_counts: got rx=%0d tx=%0d done=%0d, required 4 4 1",
                     rx_cnt[0] - r0, tx_cnt[0] - t0, done_cnt[0] - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        d0 = done_cnt[0];
        for (int i = 0; i < 4; i++) begin
            tx_q0.push_back(8'hF0 + 8'(i)); exp_mosi.push_back(8'hF0 + 8'(i));
            slave_q.push_back(8'h90 + 8'(i)); exp_rx.push_back({1'b0, 8'h90 + 8'(i)});
        end
        len_i = 8'h03;
        @(negedge clk_i);
        req_i = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (rx_valid_o[0]) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 2'b00;
        @(negedge clk_i);
        chk_cnt++;
        if ({m_en_o, gnt_o, busy_o} !== 4'b0000)
            $display("FAIL reset_mid: got en=%b gnt=%b busy=%b, required 0 00 0", m_en_o, gnt_o, busy_o);
        else pass_cnt++;
        rst_i = 1'b0;
        tx_q0.delete(); exp_mosi.delete(); slave_q.delete(); exp_rx.delete();
        repeat (20) @(negedge clk_i);
        chk_cnt++;
        if (done_cnt[0] - d0 != 0)
            $display("FAIL reset_no_done: got %0d, required 0", done_cnt[0] - d0);
        else pass_cnt++;
        tx_q0.push_back(8'h5A); exp_mosi.push_back(8'h5A);
        slave_q.push_back(8'hA5); exp_rx.push_back({1'b0, 8'hA5});
        len_i = 8'h00;
        @(negedge clk_i);
        req_i = 2'b01;
        wait_done(0, ok);
        req_i = 2'b00;
        chk_cnt++;
        if (!ok || rx_data_o !== 8'hA5)
            $display("FAIL reset_recover: got ok=%0d rx=%02h, required 1 a5", ok, rx_data_o);
        else pass_cnt++;
        wait_idle(ok);
    endtask

    task automatic test_stray_ready;
        @(negedge clk_i);
        stray_ready = 1'b1;
        @(negedge clk_i);
        stray_ready = 1'b0;
        chk_cnt++;
        if ({rx_valid_o, busy_o, rx_data_o} !== {2'b00, 1'b0, 8'hA5})
            $display("FAIL stray_ready: got rxv=%b busy=%b rx=%02h, required 00 0 a5",
                     rx_valid_o, busy_o, rx_data_o);
        else pass_cnt++;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 2'b00; len_i = 8'h00; tx_data_i = 16'h0000; stray_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin tx_cnt[k] = 0; rx_cnt[k] = 0; done_cnt[k] = 0; end
        test_reset();
        test_single();
        test_burst();
        test_contention();
        test_drop();
        test_reset_mid();
        test_stray_ready();
        repeat (5) @(negedge clk_i);
        chk_cnt++;
        if (exp_mosi.size() != 0 || exp_rx.size() != 0 || slave_q.size() != 0)
            $display("FAIL leftover: got mosi=%0d rx=%0d slave=%0d, required 0 0 0",
                     exp_mosi.size(), exp_rx.size(), slave_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
